// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline register: slot states,
// write-back select codes and the packed bundle width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_RAM = 2'd1;
    localparam logic [1:0] WSEL_PC4 = 2'd2;
    localparam logic [1:0] WSEL_IMM = 2'd3;

    function automatic int unsigned bundle_w(input int unsigned wsel_w,
                                             input int unsigned data_w,
                                             input int unsigned reg_addr_w);
        return wsel_w + 2 + 3 * data_w + reg_addr_w;
    endfunction

    // Packed width at default parameters (105 bits).
    localparam int unsigned BUNDLE_W = bundle_w(2, 32, 5);

endpackage

// File: rtl/pipe_slot.sv
// One bundle-wide storage register with load enable and asynchronous
// reset-to-zero; used for both the main and the skid slot.
module pipe_slot
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: the payload is reset even though out_valid already masks it, so
    // the MEM stage never sees X on its inputs after power-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX->MEM pipeline register with valid/ready handshake, flush and
// bubble-gated write enables. Define EX_MEM_SKID_EN for the skid-slot build.
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned WSEL_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WSEL_W-1:0]     in_rf_wsel,
    input  logic                  in_rf_we,
    input  logic                  in_ram_we,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_wd,
    input  logic [DATA_W-1:0]     in_rD2,
    input  logic [REG_ADDR_W-1:0] in_wR,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WSEL_W-1:0]     out_rf_wsel,
    output logic                  out_rf_we,
    output logic                  out_ram_we,
    output logic [DATA_W-1:0]     out_alu,
    output logic [DATA_W-1:0]     out_wd,
    output logic [REG_ADDR_W-1:0] out_wR,
    output logic [DATA_W-1:0]     out_rD2,
    output logic [1:0]            occupancy
);

    localparam int unsigned BW = bundle_w(WSEL_W, DATA_W, REG_ADDR_W);

    logic [BW-1:0] in_bundle;
    logic [BW-1:0] main_d;
    logic [BW-1:0] main_q;
    logic          main_load;
    logic          main_rf_we;
    logic          main_ram_we;
    logic          accept;
    logic          drain;
    state_e        state_q;
    state_e        state_d;

    assign in_bundle = {in_rf_wsel, in_rf_we, in_ram_we, in_alu, in_wd, in_rD2, in_wR};
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

`ifdef EX_MEM_SKID_EN
    logic [BW-1:0] skid_q;
    logic          skid_load;
    logic          main_from_skid;
    logic          in_ready_q;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    state_d   = ST_TWO;
                    skid_load = 1'b1;
                end else if (accept) begin
                    main_load = 1'b1;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d        = ST_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over everything; stale payload is left in place.
        if (flush) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_bundle;

    pipe_slot #(.W(BW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_bundle),
        .q    (skid_q)
    );

    // Registered ready breaks the out_ready -> in_ready timing path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = state_q;
`else
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept) begin
                    main_load = 1'b1;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d   = ST_EMPTY;
            main_load = 1'b0;
        end
    end

    assign main_d    = in_bundle;
    assign in_ready  = !out_valid | out_ready;
    assign occupancy = {1'b0, out_valid};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(.W(BW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    assign {out_rf_wsel, main_rf_we, main_ram_we, out_alu, out_wd, out_rD2, out_wR} = main_q;

    // A bubble or flushed entry must never write, whatever stale payload it holds.
    assign out_rf_we  = main_rf_we & out_valid;
    assign out_ram_we = main_ram_we & out_valid;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed scoreboard bench for ex_mem_pipe_reg; covers both builds
// depending on EX_MEM_SKID_EN.
module tb_ex_mem_pipe_reg;
    import pipe_pkg::*;

`ifdef EX_MEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  wsel;
        logic        rf_we;
        logic        ram_we;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] rd2;
        logic [4:0]  wr;
    } bun_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_rf_wsel;
    logic        in_rf_we;
    logic        in_ram_we;
    logic [31:0] in_alu;
    logic [31:0] in_wd;
    logic [31:0] in_rD2;
    logic [4:0]  in_wR;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_rf_wsel;
    logic        out_rf_we;
    logic        out_ram_we;
    logic [31:0] out_alu;
    logic [31:0] out_wd;
    logic [4:0]  out_wR;
    logic [31:0] out_rD2;
    logic [1:0]  occupancy;

    bun_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   model_occ;
    logic model_rdy_q;

    always #5 clk = ~clk;

    ex_mem_pipe_reg dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rf_wsel  (in_rf_wsel),
        .in_rf_we    (in_rf_we),
        .in_ram_we   (in_ram_we),
        .in_alu      (in_alu),
        .in_wd       (in_wd),
        .in_rD2      (in_rD2),
        .in_wR       (in_wR),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rf_wsel (out_rf_wsel),
        .out_rf_we   (out_rf_we),
        .out_ram_we  (out_ram_we),
        .out_alu     (out_alu),
        .out_wd      (out_wd),
        .out_wR      (out_wR),
        .out_rD2     (out_rD2),
        .occupancy   (occupancy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bun_t mk(input logic [1:0] wsel, input logic rf_we, input logic ram_we,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [31:0] rd2, input logic [4:0] wr);
        bun_t b;
        b.wsel = wsel; b.rf_we = rf_we; b.ram_we = ram_we;
        b.alu = alu; b.wd = wd; b.rd2 = rd2; b.wr = wr;
        return b;
    endfunction

    // Drive one cycle of stimulus, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic cycle(input logic v, input logic ordy, input logic fl, input bun_t b);
        logic exp_rdy;
        logic acc;
        logic drn;
        in_valid   = v;
        out_ready  = ordy;
        flush      = fl;
        in_rf_wsel = b.wsel;
        in_rf_we   = b.rf_we;
        in_ram_we  = b.ram_we;
        in_alu     = b.alu;
        in_wd      = b.wd;
        in_rD2     = b.rd2;
        in_wR      = b.wr;
        #1;
        exp_rdy = SKID ? model_rdy_q : ((model_occ == 0) || ordy);
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        check("occupancy", 128'(occupancy), 128'(model_occ));
        check("out_valid", 128'(out_valid), 128'(model_occ != 0));
        if (model_occ != 0) begin
            check("payload", {out_rf_wsel, out_alu, out_wd, out_rD2, out_wR},
                  {sb[0].wsel, sb[0].alu, sb[0].wd, sb[0].rd2, sb[0].wr});
            check("out_rf_we", 128'(out_rf_we), 128'(sb[0].rf_we));
            check("out_ram_we", 128'(out_ram_we), 128'(sb[0].ram_we));
        end else begin
            check("out_rf_we_bubble", 128'(out_rf_we), 128'(1'b0));
            check("out_ram_we_bubble", 128'(out_ram_we), 128'(1'b0));
        end
        acc = v & exp_rdy;
        drn = (model_occ != 0) & ordy;
        @(posedge clk);
        if (fl) begin
            sb.delete();
            model_occ = 0;
        end else begin
            if (drn) sb.delete(0);
            if (acc) sb.push_back(b);
            model_occ = model_occ - int'(drn) + int'(acc);
        end
        model_rdy_q = (model_occ != 2);
        @(negedge clk);
    endtask

    initial begin
        bun_t idle;
        bun_t db;
        idle = mk(WSEL_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        db   = mk(WSEL_RAM, 1'b1, 1'b0, 32'hDEADBEEF, 32'h1111_2222, 32'h3333_4444, 5'd9);

        // Reset asserted with a valid bundle on the inputs.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        in_rf_wsel = db.wsel; in_rf_we = db.rf_we; in_ram_we = db.ram_we;
        in_alu = db.alu; in_wd = db.wd; in_rD2 = db.rd2; in_wR = db.wr;
        model_occ = 0; model_rdy_q = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_outputs", {out_rf_wsel, out_rf_we, out_ram_we, out_alu, out_wd, out_rD2, out_wR}, 128'(0));
        rst = 1'b0;

        // First edge after release captures the held bundle.
        cycle(1'b1, 1'b1, 1'b0, db);
        #1;
        check("first_out_alu", 128'(out_alu), 128'(32'hDEADBEEF));

        // Back-to-back stream of eight bundles.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0,
                  mk(2'(i), i[0], 1'b0, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), 5'(i)));
        end
        cycle(1'b0, 1'b1, 1'b0, idle);
        cycle(1'b0, 1'b1, 1'b0, idle);

`ifdef EX_MEM_SKID_EN
        // Stalled consumer fills the skid slot, then releases it in order.
        cycle(1'b1, 1'b0, 1'b0, mk(WSEL_PC4, 1'b1, 1'b0, 32'hA3, 32'hB3, 32'hC3, 5'd3));
        cycle(1'b1, 1'b0, 1'b0, mk(WSEL_IMM, 1'b1, 1'b0, 32'hA4, 32'hB4, 32'hC4, 5'd4));
        cycle(1'b1, 1'b0, 1'b0, mk(WSEL_ALU, 1'b1, 1'b0, 32'hA5, 32'hB5, 32'hC5, 5'd5));
        cycle(1'b0, 1'b1, 1'b0, idle);
        cycle(1'b0, 1'b1, 1'b0, idle);
        cycle(1'b0, 1'b1, 1'b0, idle);
`endif

        // Flush with a full register and a write-enabled bundle arriving.
        cycle(1'b1, 1'b0, 1'b0, mk(WSEL_ALU, 1'b1, 1'b1, 32'hF1, 32'hF2, 32'hF3, 5'd7));
        cycle(1'b1, 1'b0, 1'b0, mk(WSEL_RAM, 1'b1, 1'b1, 32'hE1, 32'hE2, 32'hE3, 5'd8));
        cycle(1'b1, 1'b1, 1'b1, mk(WSEL_PC4, 1'b1, 1'b1, 32'hD1, 32'hD2, 32'hD3, 5'd10));
        cycle(1'b0, 1'b0, 1'b0, idle);

        // Store bundle held for three stalled cycles, drained exactly once.
        cycle(1'b1, 1'b1, 1'b0, mk(WSEL_ALU, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0000_00FF, 5'd0));
        repeat (3) cycle(1'b0, 1'b0, 1'b0, idle);
        cycle(1'b0, 1'b1, 1'b0, idle);
        cycle(1'b0, 1'b1, 1'b0, idle);

        // Asynchronous reset between edges drops a held entry at once.
        cycle(1'b1, 1'b0, 1'b0, mk(WSEL_IMM, 1'b1, 1'b0, 32'h77, 32'h88, 32'h99, 5'd12));
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(1'b0));
        check("async_rst_alu", 128'(out_alu), 128'(0));
        rst = 1'b0;
        sb.delete();
        model_occ = 0;
        model_rdy_q = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, idle);

`ifndef EX_MEM_SKID_EN
        // in_ready tracks out_ready combinationally while an entry is held.
        cycle(1'b1, 1'b0, 1'b0, mk(WSEL_RAM, 1'b1, 1'b0, 32'h55, 32'h66, 32'h77, 5'd13));
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("comb_ready_low", 128'(in_ready), 128'(1'b0));
        out_ready = 1'b1;
        #1;
        check("comb_ready_high", 128'(in_ready), 128'(1'b1));
        cycle(1'b0, 1'b1, 1'b0, idle);
        cycle(1'b0, 1'b1, 1'b0, idle);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised, elastic EX→MEM pipeline register carrying the execute-stage result bundle into the memory stage. It adds a valid/ready handshake, synchronous flush, and bubble-safe write enables. An optional compiled-in skid slot gives full throughput with a registered `in_ready`. It sits between the ALU/EX logic and the data-RAM/MEM stage, and is built so the hazard unit can stall and kill entries without glue logic.

## Interface
- `DATA_W`, 32, width of `alu`, `wd`, `rD2` payload fields
- `REG_ADDR_W`, 5, destination register index width
- `WSEL_W`, 2, write-back source select width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high
- `flush`  in  1  synchronous kill of every held entry
- `in_valid`  in  1  EX bundle valid
- `in_ready`  out  1  register can accept this cycle
- `in_rf_wsel`  in  WSEL_W  write-back select
- `in_rf_we`  in  1  register-file write enable
- `in_ram_we`  in  1  data-RAM write enable
- `in_alu`, `in_wd`, `in_rD2`  in  DATA_W each  ALU result, write-back data, store data
- `in_wR`  in  REG_ADDR_W  destination register
- `out_valid`  out  1  MEM bundle valid
- `out_ready`  in  1  MEM stage consumes this cycle
- `out_rf_wsel`, `out_rf_we`, `out_ram_we`, `out_alu`, `out_wd`, `out_wR`, `out_rD2`  out  the input widths  held bundle
- `occupancy`  out  2  entries held, 0..2

## Operation
- Handshake: accept = `in_valid & in_ready`; drain = `out_valid & out_ready`. Payload transfers only on accept. Fields sampled at `in_*` are not required stable while `in_ready`=0.
- Storage: main slot drives `out_*`. With the skid slot, three states exist: EMPTY (occ 0), ONE (main full), TWO (main + skid full).
- EMPTY:
  - accept → ONE, main ← input.
- ONE:
  - accept & !drain → TWO, skid ← input.
  - accept & drain → ONE, main ← input.
  - !accept & drain → EMPTY.
- TWO:
  - `in_ready`=0.
  - drain → ONE, main ← skid.
- Flush: next state EMPTY regardless of accept/drain in the same cycle. The incoming bundle is discarded. Payload registers keep stale data.
- Flush and reset differ: reset additionally zeroes all payload registers. Flush does not.
- Bubble safety: `out_rf_we = main_rf_we & out_valid`, `out_ram_we = main_ram_we & out_valid`. A killed or empty entry never writes.
- `occupancy` = 0/1/2 per state.
- Reset values:
  - `out_valid`=0; all `out_*` payloads 0; `occupancy`=0.
  - `in_ready`=1.
- Reset mid-operation drops all entries immediately, asynchronously.

## Timing
- Latency: accepted bundle appears on `out_*` the next rising edge (1 cycle). The skid path adds 1 cycle per stalled entry.
- Throughput: 1 bundle/cycle while `out_ready`=1.
- With skid: `in_ready` is a register output, computed as next-state ≠ TWO. There is no combinational path `out_ready`→`in_ready`.
- Without skid: `in_ready = !out_valid | out_ready`, combinational.
- `flush` does not gate `in_ready`. The accept is simply discarded.
- Simultaneous accept + drain in ONE keeps ONE with new data. Main is never overwritten while `out_valid` & !`out_ready`.

## Configuration
- `EX_MEM_SKID_EN` defined: skid slot instantiated, states EMPTY/ONE/TWO, registered `in_ready`, `occupancy` 0..2.
- `EX_MEM_SKID_EN` undefined: main slot only, states EMPTY/ONE, combinational `in_ready` as above, `occupancy` 0..1 (bit 1 tied 0).
- Handshake semantics, flush, and bubble gating are identical in both builds.

## Structure
- Shared package `pipe_pkg` holds:
  - State encodings `ST_EMPTY`/`ST_ONE`/`ST_TWO`.
  - Write-back select constants: `WSEL_ALU`=0, `WSEL_RAM`=1, `WSEL_PC4`=2, `WSEL_IMM`=3.
  - Bundle width localparam: `WSEL_W+2+3*DATA_W+REG_ADDR_W` (105 at defaults).
- Sub-module `pipe_slot`: one bundle-wide register with load enable and async reset-to-zero. It is instantiated once as main, and once more as skid under `EX_MEM_SKID_EN`.

## Test plan
- Reset with `in_valid`=1, `in_alu`=32'hDEADBEEF → `out_valid`=0, all `out_*`=0, `in_ready`=1, `occupancy`=0; first edge after release → `out_alu`=32'hDEADBEEF.
- Stream 8 bundles (`in_wR`=1..8) with `out_ready`=1 → outputs appear 1 cycle later in order, no gaps, `occupancy`=1 throughout.
- Skid build: hold `out_ready`=0, push `in_wR`=3 then 4 → `occupancy`=2, `in_ready`=0 next cycle. Release → `out_wR`=3 then 4, `in_ready`=1 after the first drain.
- `flush`=1 with `occupancy`=2 and `in_valid`=1, `in_rf_we`=1 → next cycle `out_valid`=0, `out_rf_we`=0, `out_ram_we`=0, `occupancy`=0.
- Store bundle `in_ram_we`=1, `in_rD2`=32'h0000_00FF accepted, then `out_ready`=0 for 3 cycles → `out_ram_we`=1 and `out_rD2` stable all 3 cycles, with no duplicate drain.
- Non-skid build: `out_valid`=1, toggle `out_ready` 0→1 → `in_ready` follows combinationally in the same cycle.
